hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flush bubbles and permanent halt.
// Optional HAZARD_CTRL_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned FLUSH_SLOTS = 2,
    parameter logic [5:0]  OP_NOP      = 6'b000111,
    parameter logic [5:0]  OP_LOAD     = 6'b001000,
    parameter logic [5:0]  OP_HALT     = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op_id,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic [4:0]  rd_id,
    input  logic        branch_taken,
    output logic        pc_en,
    output logic        ins_cs,
    output logic [5:0]  issue_op,
    output logic        halted
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt_tot
`endif
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;
    localparam int unsigned FC_W  = 2;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic [1:0]       state,     state_nxt;
    logic [OP_W-1:0]  issue_nxt;
    logic             halted_nxt;
    logic             ld_pend,   ld_pend_nxt;
    logic [REG_W-1:0] ld_rd,     ld_rd_nxt;
    logic [FC_W-1:0]  flush_cnt, flush_nxt;

    logic uses_rs;
    logic uses_rt;
    logic is_load;
    logic hz;

    // Operand-usage decode of the fetched opcode and load-use hazard detect
    always_comb begin
        uses_rs = (op_id <= 6'd5) || ((op_id >= 6'd9) && (op_id <= 6'd14));
        uses_rt = (op_id <= 6'd5) || (op_id == 6'd9);
        is_load = (op_id == OP_LOAD);
        hz      = ld_pend && ((uses_rs && (rs_id == ld_rd)) ||
                              (uses_rt && (rt_id == ld_rd)));
    end

    // Fetch enable: held on a hazard or halt, free-running while bubbles drain
    always_comb begin
        pc_en = 1'b0;
        case (state)
            ST_RUN:   pc_en = !hz && (op_id != OP_HALT);
            ST_STALL: pc_en = 1'b1;
            ST_FLUSH: pc_en = 1'b1;
            default:  pc_en = 1'b0;
        endcase
        ins_cs = pc_en;
    end

    // Next-state and registered-output decisions
    always_comb begin
        state_nxt   = state;
        issue_nxt   = issue_op;
        halted_nxt  = halted;
        ld_pend_nxt = ld_pend;
        ld_rd_nxt   = ld_rd;
        flush_nxt   = flush_cnt;

        case (state)
            ST_RUN: begin
                if (branch_taken) begin
                    issue_nxt   = OP_NOP;
                    ld_pend_nxt = 1'b0;
                    if (FLUSH_SLOTS > 1) begin
                        flush_nxt = FC_W'(FLUSH_SLOTS - 1);
                        state_nxt = ST_FLUSH;
                    end
                end else if (hz) begin
                    issue_nxt   = OP_NOP;
                    ld_pend_nxt = 1'b0;
                    state_nxt   = ST_STALL;
                end else if (op_id == OP_HALT) begin
                    issue_nxt  = OP_HALT;
                    halted_nxt = 1'b1;
                    state_nxt  = ST_HALT;
                end else begin
                    issue_nxt   = op_id;
                    ld_pend_nxt = is_load;
                    if (is_load) begin
                        ld_rd_nxt = rd_id;
                    end
                end
            end
            ST_STALL: begin
                // The held instruction is re-presented and issues now
                issue_nxt   = op_id;
                ld_pend_nxt = is_load;
                if (is_load) begin
                    ld_rd_nxt = rd_id;
                end
                state_nxt = ST_RUN;
            end
            ST_FLUSH: begin
                issue_nxt   = OP_NOP;
                ld_pend_nxt = 1'b0;
                flush_nxt   = flush_cnt - FC_W'(1);
                if (flush_cnt == FC_W'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                issue_nxt = OP_NOP;
            end
            default: begin
                state_nxt = ST_RUN;
                issue_nxt = OP_NOP;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            issue_op  <= OP_NOP;
            halted    <= 1'b0;
            ld_pend   <= 1'b0;
            ld_rd     <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            issue_op  <= issue_nxt;
            halted    <= halted_nxt;
            ld_pend   <= ld_pend_nxt;
            ld_rd     <= ld_rd_nxt;
            flush_cnt <= flush_nxt;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    localparam int unsigned PC_W = 16;

    logic stall_inc;
    logic flush_inc;

    // Event strobes: RUN->STALL edges, and every bubble caused by a taken branch
    always_comb begin
        stall_inc = (state == ST_RUN) && !branch_taken && hz;
        flush_inc = ((state == ST_RUN) && branch_taken) || (state == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt     <= '0;
            flush_cnt_tot <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {PC_W{1'b1}})) begin
                stall_cnt <= stall_cnt + PC_W'(1);
            end
            if (flush_inc && (flush_cnt_tot != {PC_W{1'b1}})) begin
                flush_cnt_tot <= flush_cnt_tot + PC_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: instruction-level reference model checked every cycle plus literal pins.
module tb_hazard_ctrl;

    localparam int unsigned FS = 2;
    localparam logic [5:0] NOP  = 6'b000111;
    localparam logic [5:0] LOAD = 6'b001000;
    localparam logic [5:0] HALT = 6'b111111;
    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op_id = NOP;
    logic [4:0]  rs_id = '0;
    logic [4:0]  rt_id = '0;
    logic [4:0]  rd_id = '0;
    logic        branch_taken = 1'b0;
    logic        pc_en;
    logic        ins_cs;
    logic [5:0]  issue_op;
    logic        halted;
`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt_tot;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    hazard_ctrl #(.FLUSH_SLOTS(FS)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_id        (op_id),
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .rd_id        (rd_id),
        .branch_taken (branch_taken),
        .pc_en        (pc_en),
        .ins_cs       (ins_cs),
        .issue_op     (issue_op),
        .halted       (halted)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt_tot(flush_cnt_tot)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pending load destination (-1 = none), bubbles still owed, held instruction
    int         pend      = -1;
    int         bubbles   = 0;
    bit         held      = 1'b0;
    bit         hlt       = 1'b0;
    logic [5:0] m_issue   = NOP;
    int         m_stalls  = 0;
    int         m_flushes = 0;

    function automatic bit reads_rs(input logic [5:0] op);
        int o = int'(op);
        return (o <= 5) || (o >= 9 && o <= 14);
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        int o = int'(op);
        return (o <= 5) || (o == 9);
    endfunction

    function automatic bit dep(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        if (pend < 0) return 1'b0;
        return (reads_rs(op) && int'(rs) == pend) || (reads_rt(op) && int'(rt) == pend);
    endfunction

    function automatic bit m_pc_en();
        if (hlt) return 1'b0;
        if (held || bubbles > 0) return 1'b1;
        return !dep(op_id, rs_id, rt_id) && (op_id != HALT);
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend = -1; bubbles = 0; held = 1'b0; hlt = 1'b0;
            m_issue = NOP; m_stalls = 0; m_flushes = 0;
        end else if (hlt) begin
            m_issue = NOP;
        end else if (held) begin
            m_issue = op_id;
            pend = (op_id == LOAD) ? int'(rd_id) : -1;
            held = 1'b0;
        end else if (bubbles > 0) begin
            m_issue = NOP;
            bubbles = bubbles - 1;
            m_flushes = sat(m_flushes + 1);
        end else if (branch_taken) begin
            m_issue = NOP;
            pend = -1;
            bubbles = int'(FS) - 1;
            m_flushes = sat(m_flushes + 1);
        end else if (dep(op_id, rs_id, rt_id)) begin
            m_issue = NOP;
            pend = -1;
            held = 1'b1;
            m_stalls = sat(m_stalls + 1);
        end else if (op_id == HALT) begin
            m_issue = HALT;
            hlt = 1'b1;
        end else begin
            m_issue = op_id;
            pend = (op_id == LOAD) ? int'(rd_id) : -1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc_en", 16'(pc_en), 16'(m_pc_en()));
            chk("ins_cs", 16'(ins_cs), 16'(m_pc_en()));
            chk("issue_op", 16'(issue_op), 16'(m_issue));
            chk("halted", 16'(halted), 16'(hlt));
`ifdef HAZARD_CTRL_PERF_EN
            chk("stall_cnt", stall_cnt, 16'(m_stalls));
            chk("flush_cnt_tot", flush_cnt_tot, 16'(m_flushes));
`endif
        end
    end

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic br);
        op_id = op; rs_id = rs; rt_id = rt; rd_id = rd; branch_taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_issue", 16'(issue_op), 16'(NOP));
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_pc_en", 16'(pc_en), 16'd1);
        rst = 1'b0;
        chk_en = 1'b1;

        // Load followed by a dependent ADD: one stall bubble
        drive(LOAD, 5'd0, 5'd0, 5'd5, 1'b0);
        tick();
        chk("ld_issue", 16'(issue_op), 16'(LOAD));
        drive(ADD, 5'd5, 5'd2, 5'd1, 1'b0);
        chk("hz_pc_en", 16'(pc_en), 16'd0);
        chk("hz_ins_cs", 16'(ins_cs), 16'd0);
        tick();
        chk("hz_bubble", 16'(issue_op), 16'(NOP));
        chk("stall_pc_en", 16'(pc_en), 16'd1);
        tick();
        chk("hz_held_issue", 16'(issue_op), 16'(ADD));
`ifdef HAZARD_CTRL_PERF_EN
        chk("stall_cnt_lit", stall_cnt, 16'd1);
`endif

        // Independent ADD after a load: no stall
        drive(LOAD, 5'd0, 5'd0, 5'd5, 1'b0);
        tick();
        drive(ADD, 5'd3, 5'd4, 5'd1, 1'b0);
        chk("nodep_pc_en", 16'(pc_en), 16'd1);
        tick();
        chk("nodep_issue", 16'(issue_op), 16'(ADD));

        // Immediate op ignores rt even when it matches the load destination
        drive(LOAD, 5'd0, 5'd0, 5'd7, 1'b0);
        tick();
        drive(ADDI, 5'd2, 5'd7, 5'd1, 1'b0);
        chk("addi_pc_en", 16'(pc_en), 16'd1);
        tick();
        chk("addi_issue", 16'(issue_op), 16'(ADDI));

        // Register 0 is a real dependency; rt-side dependency via SUB-class op
        drive(LOAD, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(ADD, 5'd0, 5'd0, 5'd1, 1'b0);
        chk("r0_pc_en", 16'(pc_en), 16'd0);
        tick();
        tick();
        drive(LOAD, 5'd0, 5'd0, 5'd9, 1'b0);
        tick();
        drive(6'b000001, 5'd1, 5'd9, 5'd2, 1'b0);
        chk("rt_dep_pc_en", 16'(pc_en), 16'd0);
        tick();
        tick();
        chk("rt_dep_issue", 16'(issue_op), 16'(6'b000001));

        // Taken branch: two bubbles; a branch pulse during the flush adds none
        drive(ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        chk("br_bubble1", 16'(issue_op), 16'(NOP));
        drive(6'b000010, 5'd1, 5'd2, 5'd3, 1'b1);
        chk("flush_pc_en", 16'(pc_en), 16'd1);
        tick();
        chk("br_bubble2", 16'(issue_op), 16'(NOP));
        drive(6'b000011, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        chk("br_resume", 16'(issue_op), 16'(6'b000011));

        // Branch after a load clears the pending load
        drive(LOAD, 5'd0, 5'd0, 5'd4, 1'b0);
        tick();
        drive(ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        drive(NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(ADD, 5'd4, 5'd4, 5'd1, 1'b0);
        chk("br_clr_pc_en", 16'(pc_en), 16'd1);
        tick();
        chk("br_clr_issue", 16'(issue_op), 16'(ADD));

        // Reset with a load pending: clears issue_op at once and forgets the load
        drive(LOAD, 5'd0, 5'd0, 5'd6, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_ld_issue", 16'(issue_op), 16'(NOP));
        rst = 1'b0;
        drive(ADD, 5'd6, 5'd6, 5'd1, 1'b0);
        chk("rst_ld_pc_en", 16'(pc_en), 16'd1);
        tick();
        chk("rst_ld_after", 16'(issue_op), 16'(ADD));

        // Reset during a stall: next edge must act as RUN (branch honoured)
        drive(LOAD, 5'd0, 5'd0, 5'd6, 1'b0);
        tick();
        drive(ADD, 5'd6, 5'd1, 5'd2, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_stall_issue", 16'(issue_op), 16'(NOP));
        chk("rst_stall_halted", 16'(halted), 16'd0);
        rst = 1'b0;
        drive(ADD, 5'd6, 5'd1, 5'd2, 1'b1);
        tick();
        chk("rst_stall_branch", 16'(issue_op), 16'(NOP));

        // Reset during the second flush bubble: no further bubble afterwards
        drive(6'b000010, 5'd1, 5'd2, 5'd3, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_flush_pc_en", 16'(pc_en), 16'd1);
        rst = 1'b0;
        tick();
        chk("rst_flush_issue", 16'(issue_op), 16'(6'b000010));

        // Halt is permanent until reset
        drive(HALT, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("halt_pc_en0", 16'(pc_en), 16'd0);
        tick();
        chk("halt_issue", 16'(issue_op), 16'(HALT));
        chk("halt_flag", 16'(halted), 16'd1);
        drive(ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        chk("halt_pc_en", 16'(pc_en), 16'd0);
        chk("halt_ins_cs", 16'(ins_cs), 16'd0);
        tick();
        chk("halt_nop", 16'(issue_op), 16'(NOP));
        drive(LOAD, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        chk("halt_nop2", 16'(issue_op), 16'(NOP));
        chk("halt_sticky", 16'(halted), 16'd1);
        rst = 1'b1;
        #1;
        chk("halt_rst", 16'(halted), 16'd0);
        rst = 1'b0;
        drive(6'b000011, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        chk("post_halt_issue", 16'(issue_op), 16'(6'b000011));
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
